// File: rtl/bus_target_pkg.sv
// Shared types and constants for the CPU bus responder.
// Optional zero-page RAM is enabled by BUS_TARGET_ZP_RAM_EN.
package bus_target_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W = 8;

    localparam logic [7:0] ERR_DATA_DEF = 8'hFF;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } xreq_t;

endpackage

// File: rtl/bus_target_zp.sv
// 256x8 zero-page RAM: synchronous write, combinational read so the
// caller can register the read data at the same edge it samples the address.
module zp_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_target.sv
// CPU bus responder: forwards accesses to an external handshake with timeout.
// Define BUS_TARGET_ZP_RAM_EN to serve page zero from an internal RAM.
module bus_target
    import bus_target_pkg::*;
#(
    parameter int         TIMEOUT  = 16,
    parameter logic [7:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] AB,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    xreq_t            req;
    logic             zp_hit;
    logic [7:0]       zp_rdata;

`ifdef BUS_TARGET_ZP_RAM_EN
    assign zp_hit = (AB[15:8] == 8'h00);

    zp_ram u_zp_ram (
        .clk   (clk),
        .we    ((state == IDLE) && zp_hit && WE),
        .addr  (AB[7:0]),
        .wdata (DO),
        .rdata (zp_rdata)
    );
`else
    assign zp_hit   = 1'b0;
    assign zp_rdata = 8'h00;
`endif

    assign mem_addr  = req.addr;
    assign mem_we    = req.we;
    assign mem_wdata = req.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            DI      <= 8'h00;
            RDY     <= 1'b1;
            bus_err <= 1'b0;
            mem_req <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (zp_hit) begin
                        if (!WE) begin
                            DI <= zp_rdata;
                        end
                    end else begin
                        req     <= '{addr: AB, we: WE, wdata: DO};
                        mem_req <= 1'b1;
                        RDY     <= 1'b0;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // ack beats a coincident timeout
                    if (mem_ack) begin
                        if (!req.we) begin
                            DI <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        RDY     <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        if (!req.we) begin
                            DI <= ERR_DATA;
                        end
                        bus_err <= 1'b1;
                        mem_req <= 1'b0;
                        RDY     <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_target.sv
// Scoreboard bench for bus_target: expected DI queued per access.
// Adapts to BUS_TARGET_ZP_RAM_EN for zero-page accesses.
module tb_bus_target;

    localparam int         TO   = 16;
    localparam logic [7:0] ERRD = 8'hFF;

`ifdef BUS_TARGET_ZP_RAM_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        RDY;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    logic [7:0] model_di;
    logic [7:0] zp_mem [int];

    always #5 clk = ~clk;

    bus_target #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERRD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AB        (AB),
        .WE        (WE),
        .DO        (DO),
        .DI        (DI),
        .RDY       (RDY),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with RDY=1; ack_at<0 means never ack.
    task automatic access(input logic [15:0] a, input logic w,
                          input logic [7:0] d, input int ack_at,
                          input logic [7:0] rd, input bit idle_ack);
        int   low;
        int   exp_low;
        bit   zp;
        logic exp_err;
        zp      = ZP && (a[15:8] == 8'h00);
        exp_err = !zp && (ack_at < 0);
        exp_low = (ack_at > 0) ? ack_at : TO;
        if (zp) begin
            if (w) zp_mem[int'(a[7:0])] = d;
            else   model_di = zp_mem[int'(a[7:0])];
        end else if (!w) begin
            model_di = (ack_at < 0) ? ERRD : rd;
        end
        exp_q.push_back(model_di);
        AB = a;
        WE = w;
        DO = d;
        if (idle_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
        end
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        if (zp) begin
            chk("zp_rdy", 32'(RDY), 32'd1);
            chk("zp_req", 32'(mem_req), 32'd0);
            chk("zp_di", 32'(DI), 32'(exp_q.pop_front()));
            return;
        end
        chk("rdy_low", 32'(RDY), 32'd0);
        chk("req", 32'(mem_req), 32'd1);
        chk("addr", 32'(mem_addr), 32'(a));
        chk("we", 32'(mem_we), 32'(w));
        chk("wdata", 32'(mem_wdata), 32'(d));
        chk("err_clr", 32'(bus_err), 32'd0);
        low = 0;
        while (RDY === 1'b0 && low < 300) begin
            low++;
            if (low == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
            if (RDY === 1'b0) chk("hold_addr", 32'(mem_addr), 32'(a));
        end
        chk("rdy_back", 32'(RDY), 32'd1);
        chk("low_cyc", 32'(low), 32'(exp_low));
        chk("bus_err", 32'(bus_err), 32'(exp_err));
        chk("req_off", 32'(mem_req), 32'd0);
        chk("di", 32'(DI), 32'(exp_q.pop_front()));
    endtask

    initial begin
        rst_n     = 1'b0;
        AB        = 16'h1234;
        WE        = 1'b0;
        DO        = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        model_di  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(RDY), 32'd1);
        chk("rst_di", 32'(DI), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;

        access(16'h1234, 1'b0, 8'h00, 3, 8'hA5, 1'b0);
        access(16'h8000, 1'b1, 8'h3C, 1, 8'h00, 1'b0);
        access(16'h4000, 1'b0, 8'h00, -1, 8'h00, 1'b0);
        access(16'h4001, 1'b0, 8'h00, TO, 8'h11, 1'b0);
        access(16'h9000, 1'b1, 8'h55, -1, 8'h00, 1'b0);
        access(16'hFFFF, 1'b0, 8'h00, 2, 8'h3E, 1'b0);
        access(16'h0042, 1'b1, 8'h77, 2, 8'h00, 1'b0);
        access(16'h0042, 1'b0, 8'h00, 2, 8'h77, 1'b0);

        AB = 16'h5000;
        WE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_rdy", 32'(RDY), 32'd1);
        chk("arst_di", 32'(DI), 32'd0);
        model_di = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        access(16'h2000, 1'b0, 8'h00, 2, 8'h5A, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bus_target.md
BUS_TARGET -- requirements
Module: bus_target

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum BUSY cycles before an external access is aborted (range 2..255).
REQ-002 Parameter ERR_DATA, default 8'hFF, value returned on DI for an aborted read.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 AB  input  16  CPU address, valid while RDY=1.
REQ-006 WE  input  1  CPU write strobe, valid while RDY=1.
REQ-007 DO  input  8  CPU write data, valid while RDY=1.
REQ-008 DI  output  8  registered read data to CPU.
REQ-009 RDY  output  1  CPU stall control; 0 stalls the CPU.
REQ-010 bus_err  output  1  one-cycle pulse on access abort.
REQ-011 mem_req  output  1  external request, held until ack or abort.
REQ-012 mem_we  output  1  external write qualifier.
REQ-013 mem_addr  output  16  external address.
REQ-014 mem_wdata  output  8  external write data.
REQ-015 mem_rdata  input  8  external read data, valid with mem_ack.
REQ-016 mem_ack  input  1  external completion, one cycle.

Function
REQ-017 The block SHALL be the responder to the CPU address/data bus and treat every clock edge with RDY=1 as sampling one access (AB, WE, DO).
REQ-018 The block SHALL implement states IDLE and BUSY.
REQ-019 In IDLE, a sampled external access SHALL latch AB/WE/DO into mem_addr/mem_we/mem_wdata, set mem_req=1, drive RDY=0 and enter BUSY, all at the same edge.
REQ-020 In BUSY, mem_addr/mem_we/mem_wdata SHALL stay constant and RDY SHALL stay 0.
REQ-021 On mem_ack=1 in BUSY: for a read, DI SHALL load mem_rdata; for a write, DI SHALL hold its value; mem_req->0, RDY->1, state->IDLE at that edge.
REQ-022 Minimum external access latency SHALL be 2 cycles (sample edge + ack edge); the CPU sees new DI the cycle RDY returns to 1.
REQ-023 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-024 When the counter reaches TIMEOUT-1 without ack, the block SHALL abort: DI=ERR_DATA (reads only), bus_err=1 for one cycle, mem_req->0, RDY->1, state->IDLE.
REQ-025 mem_ack in the same cycle as the timeout condition SHALL win: normal completion, no bus_err.
REQ-026 mem_ack received in IDLE SHALL be ignored.
REQ-027 The counter SHALL saturate and never wrap.

Reset
REQ-028 While rst_n=0: state=IDLE, RDY=1, DI=8'h00, mem_req=0, mem_we=0, mem_addr=16'h0000, mem_wdata=8'h00, bus_err=0, counter=0.
REQ-029 Reset asserted during BUSY SHALL drop mem_req immediately (asynchronously); the pending access is discarded.
REQ-030 The first edge after rst_n rises SHALL sample an access (RDY=1).

Configuration
REQ-031 Macro BUS_TARGET_ZP_RAM_EN SHALL enable an internal 256x8 zero-page RAM.
REQ-032 With the macro: an IDLE access with AB[15:8]=8'h00 SHALL be served internally with zero wait states: RDY stays 1, mem_req stays 0, reads load DI from RAM[AB[7:0]] at the sample edge, writes store DO at that edge.
REQ-033 Without the macro: all addresses, including zero page, SHALL use the external handshake.

Structure
REQ-034 Package bus_target_pkg SHALL hold the state enum, the counter width constant (8) and the ERR_DATA default.
REQ-035 The zero-page RAM SHALL be a sub-module named zp_ram, instantiated only under BUS_TARGET_ZP_RAM_EN.

Verification
REQ-036 Read AB=16'h1234, mem_ack 3 cycles later with mem_rdata=8'hA5 -> mem_addr=16'h1234, RDY=0 for 3 cycles, DI=8'hA5 with RDY=1.
REQ-037 Write AB=16'h8000, DO=8'h3C, immediate ack -> mem_we=1, mem_wdata=8'h3C, RDY low exactly 1 cycle, DI unchanged.
REQ-038 Read, no ack, TIMEOUT=16 -> bus_err pulse 16 cycles after the sample edge, DI=8'hFF, mem_req=0.
REQ-039 Ack coincident with the timeout cycle, mem_rdata=8'h11 -> DI=8'h11, bus_err stays 0.
REQ-040 With BUS_TARGET_ZP_RAM_EN: write 8'h77 to 16'h0042, then read 16'h0042 -> RDY never low, mem_req never high, DI=8'h77; without the macro the same sequence uses the handshake.
REQ-041 rst_n low mid-BUSY -> mem_req=0 immediately, RDY=1, DI=8'h00; late mem_ack after release is ignored.
